// File: rtl/io_pkg.sv
// Shared constants, FSM state types and sizing helper for the programmed-I/O responder.
package io_pkg;

  localparam int IO_WIDTH = 16;
  localparam int IO_DEPTH = 8;

  typedef enum logic [1:0] {I_IDLE, I_ACK, I_WAIT} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_ACK, O_WAIT} out_state_t;

  // Occupancy needs one extra bit so that a full FIFO (level == depth) is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: dout presents the head word whenever the FIFO is non-empty, else 0.
module sync_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == LW'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: storage is deliberately not reset; validity comes only from the pointers and level,
  // which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/io_port_responder.sv
// Peripheral-side responder for the CPU programmed-I/O handshake: one FIFO plus one
// req/ack FSM per direction, the two directions fully independent.
module io_port_responder
  import io_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        inp_req,
  output logic                        inp_ack,
  output logic [WIDTH-1:0]            inp_data,
  input  logic                        out_req,
  input  logic [WIDTH-1:0]            out_data,
  output logic                        out_ack,
  input  logic                        src_valid,
  input  logic [WIDTH-1:0]            src_data,
  output logic                        src_ready,
  output logic                        snk_valid,
  output logic [WIDTH-1:0]            snk_data,
  input  logic                        snk_ready,
  output logic [level_w(DEPTH)-1:0]   in_level,
  output logic [level_w(DEPTH)-1:0]   out_level
);

  in_state_t        r_in_state;
  out_state_t       r_out_state;
  logic             r_inp_ack;
  logic             r_out_ack;
  logic [WIDTH-1:0] r_inp_data;

  logic [WIDTH-1:0] w_in_dout;
  logic             w_in_full;
  logic             w_in_empty;
  logic             w_in_pop;
  logic             w_out_full;
  logic             w_out_empty;
  logic             w_out_push;

  // Pops and pushes fire only from IDLE, so a request held high is served exactly once.
  assign w_in_pop   = (r_in_state == I_IDLE) & inp_req & ~w_in_empty;
  assign w_out_push = (r_out_state == O_IDLE) & out_req & ~w_out_full;

  assign src_ready = ~w_in_full;
  assign snk_valid = ~w_out_empty;
  assign inp_ack   = r_inp_ack;
  assign inp_data  = r_inp_data;
  assign out_ack   = r_out_ack;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (src_valid & ~w_in_full),
    .pop   (w_in_pop),
    .din   (src_data),
    .dout  (w_in_dout),
    .full  (w_in_full),
    .empty (w_in_empty),
    .level (in_level)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (w_out_push),
    .pop   (snk_ready & ~w_out_empty),
    .din   (out_data),
    .dout  (snk_data),
    .full  (w_out_full),
    .empty (w_out_empty),
    .level (out_level)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_in_state <= I_IDLE;
      r_inp_ack  <= 1'b0;
      r_inp_data <= '0;
    end else begin
      r_inp_ack <= 1'b0;
      case (r_in_state)
        I_IDLE: if (w_in_pop) begin
          r_inp_data <= w_in_dout;
          r_inp_ack  <= 1'b1;
          r_in_state <= I_ACK;
        end
        I_ACK:   r_in_state <= I_WAIT;
        I_WAIT:  if (!inp_req) r_in_state <= I_IDLE;
        default: r_in_state <= I_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_out_state <= O_IDLE;
      r_out_ack   <= 1'b0;
    end else begin
      r_out_ack <= 1'b0;
      case (r_out_state)
        O_IDLE: if (w_out_push) begin
          r_out_ack   <= 1'b1;
          r_out_state <= O_ACK;
        end
        O_ACK:   r_out_state <= O_WAIT;
        O_WAIT:  if (!out_req) r_out_state <= O_IDLE;
        default: r_out_state <= O_IDLE;
      endcase
    end
  end

endmodule
